// File: rtl/isr_bank_if.sv
// Bus bundle between the priority resolver / command decoder and the in-service register.
// The slave side is the isr_bank itself; master is whoever drives the strobes.
interface isr_bank_if #(
  parameter int NUM_IRQ = 8
);
  localparam int IDX_W = $clog2(NUM_IRQ);

  logic               setValid;
  logic [IDX_W-1:0]   setIndex;
  logic               vectorReq;
  logic [7:0]         vecBase;
  logic               aeoi;
  logic               aeoiRotate;
  logic               eoiValid;
  logic               eoiSpecific;
  logic               eoiRotate;
  logic [IDX_W-1:0]   eoiLevel;
  logic               priorityWrite;
  logic [IDX_W-1:0]   priorityLevel;

  logic [NUM_IRQ-1:0] isrValue;
  logic [IDX_W-1:0]   lowestPriority;
  logic [IDX_W-1:0]   highestIndex;
  logic               anyInService;
  logic               setAck;
  logic               vectorValid;
  logic [7:0]         vectorOut;
  logic               spurious;
  logic               eoiDone;
  logic               clearedValid;
  logic [IDX_W-1:0]   clearedIndex;
  logic               protocolError;

  modport slave (
    input  setValid, setIndex, vectorReq, vecBase, aeoi, aeoiRotate,
           eoiValid, eoiSpecific, eoiRotate, eoiLevel, priorityWrite, priorityLevel,
    output isrValue, lowestPriority, highestIndex, anyInService, setAck,
           vectorValid, vectorOut, spurious, eoiDone, clearedValid, clearedIndex,
           protocolError
  );

  modport master (
    output setValid, setIndex, vectorReq, vecBase, aeoi, aeoiRotate,
           eoiValid, eoiSpecific, eoiRotate, eoiLevel, priorityWrite, priorityLevel,
    input  isrValue, lowestPriority, highestIndex, anyInService, setAck,
           vectorValid, vectorOut, spurious, eoiDone, clearedValid, clearedIndex,
           protocolError
  );
endinterface

// File: rtl/isr_bank.sv
// In-service register for the interrupt controller: sets on first INTA, returns the
// vector on second INTA, clears on AEOI / EOI and keeps the rotating-priority pointer.
module isr_bank #(
  parameter int NUM_IRQ = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  isr_bank_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_IRQ);

  typedef enum logic {IDLE, ACKED} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   low_q, low_d;
  logic [7:0]         vecOut_q, vecOut_d;
  logic [IDX_W-1:0]   clrIdx_q, clrIdx_d;
  logic setAck_q, setAck_d, vecValid_q, vecValid_d, spurious_q, spurious_d;
  logic eoiDone_q, eoiDone_d, clrValid_q, clrValid_d, protoErr_q, protoErr_d;
  logic [IDX_W-1:0]   highest;
  logic               aeoiClear;

  // Priority search starts just above the lowest-priority line and wraps; the
  // downward loop leaves the first hit in rotation order.
  always_comb begin
    highest = low_q + IDX_W'(1);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (isr_q[low_q + IDX_W'(i + 1)]) highest = low_q + IDX_W'(i + 1);
    end
  end

  assign aeoiClear = (state_q == ACKED) && bus.vectorReq && bus.aeoi;

  always_comb begin
    state_d    = state_q;
    isr_d      = isr_q;
    idx_d      = idx_q;
    low_d      = low_q;
    vecOut_d   = vecOut_q;
    clrIdx_d   = clrIdx_q;
    setAck_d   = 1'b0;
    vecValid_d = 1'b0;
    spurious_d = 1'b0;
    eoiDone_d  = 1'b0;
    clrValid_d = 1'b0;
    protoErr_d = 1'b0;

    // EOI works on the pre-edge ISR so a same-edge set wins over it.
    if (bus.eoiValid) begin
      if (aeoiClear) begin
        protoErr_d = 1'b1;
      end else begin
        eoiDone_d = 1'b1;
        if (bus.eoiSpecific) begin
          if (isr_q[bus.eoiLevel]) begin
            isr_d[bus.eoiLevel] = 1'b0;
            clrValid_d = 1'b1;
            clrIdx_d   = bus.eoiLevel;
            if (bus.eoiRotate) low_d = bus.eoiLevel;
          end
        end else if (|isr_q) begin
          isr_d[highest] = 1'b0;
          clrValid_d = 1'b1;
          clrIdx_d   = highest;
          if (bus.eoiRotate) low_d = highest;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.vectorReq) begin
          vecOut_d   = {bus.vecBase[7:IDX_W], IDX_W'(NUM_IRQ - 1)};
          vecValid_d = 1'b1;
          spurious_d = 1'b1;
        end
        if (bus.setValid) begin
          isr_d[bus.setIndex] = 1'b1;
          idx_d    = bus.setIndex;
          setAck_d = 1'b1;
          state_d  = ACKED;
        end
      end
      ACKED: begin
        if (bus.setValid) protoErr_d = 1'b1;
        if (bus.vectorReq) begin
          vecOut_d   = {bus.vecBase[7:IDX_W], idx_q};
          vecValid_d = 1'b1;
          state_d    = IDLE;
          if (bus.aeoi) begin
            isr_d[idx_q] = 1'b0;
            eoiDone_d  = 1'b1;
            clrValid_d = 1'b1;
            clrIdx_d   = idx_q;
            if (bus.aeoiRotate) low_d = idx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.priorityWrite) low_d = bus.priorityLevel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      isr_q      <= '0;
      idx_q      <= '0;
      low_q      <= IDX_W'(NUM_IRQ - 1);
      vecOut_q   <= '0;
      clrIdx_q   <= '0;
      setAck_q   <= 1'b0;
      vecValid_q <= 1'b0;
      spurious_q <= 1'b0;
      eoiDone_q  <= 1'b0;
      clrValid_q <= 1'b0;
      protoErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      isr_q      <= isr_d;
      idx_q      <= idx_d;
      low_q      <= low_d;
      vecOut_q   <= vecOut_d;
      clrIdx_q   <= clrIdx_d;
      setAck_q   <= setAck_d;
      vecValid_q <= vecValid_d;
      spurious_q <= spurious_d;
      eoiDone_q  <= eoiDone_d;
      clrValid_q <= clrValid_d;
      protoErr_q <= protoErr_d;
    end
  end

  assign bus.isrValue       = isr_q;
  assign bus.lowestPriority = low_q;
  assign bus.highestIndex   = highest;
  assign bus.anyInService   = |isr_q;
  assign bus.setAck         = setAck_q;
  assign bus.vectorValid    = vecValid_q;
  assign bus.vectorOut      = vecOut_q;
  assign bus.spurious       = spurious_q;
  assign bus.eoiDone        = eoiDone_q;
  assign bus.clearedValid   = clrValid_q;
  assign bus.clearedIndex   = clrIdx_q;
  assign bus.protocolError  = protoErr_q;
endmodule

// File: tb/tb_isr_bank.sv
// Directed bench for isr_bank: an 8-line instance carries most vectors, a 16-line
// instance checks the wider vector composition.
module tb_isr_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  isr_bank_if #(.NUM_IRQ(8))  ifA ();
  isr_bank_if #(.NUM_IRQ(16)) ifB ();

  isr_bank #(.NUM_IRQ(8))  dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  isr_bank #(.NUM_IRQ(16)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearStrobes();
    ifA.setValid = 1'b0; ifA.vectorReq = 1'b0; ifA.eoiValid = 1'b0; ifA.priorityWrite = 1'b0;
    ifB.setValid = 1'b0; ifB.vectorReq = 1'b0; ifB.eoiValid = 1'b0; ifB.priorityWrite = 1'b0;
  endtask

  // Advance one edge, sample 1 time unit after it, then drop all strobes.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearStrobes();
  endtask

  task automatic setA(input logic [2:0] idx);
    ifA.setValid = 1'b1; ifA.setIndex = idx;
    applyStimulus();
  endtask

  task automatic vecA();
    ifA.vectorReq = 1'b1;
    applyStimulus();
  endtask

  task automatic eoiA(input logic spec, input logic rot, input logic [2:0] lvl);
    ifA.eoiValid = 1'b1; ifA.eoiSpecific = spec; ifA.eoiRotate = rot; ifA.eoiLevel = lvl;
    applyStimulus();
  endtask

  task automatic prioA(input logic [2:0] lvl);
    ifA.priorityWrite = 1'b1; ifA.priorityLevel = lvl;
    applyStimulus();
  endtask

  initial begin
    clearStrobes();
    ifA.setIndex = '0; ifA.vecBase = 8'h40; ifA.aeoi = 1'b0; ifA.aeoiRotate = 1'b0;
    ifA.eoiSpecific = 1'b0; ifA.eoiRotate = 1'b0; ifA.eoiLevel = '0; ifA.priorityLevel = '0;
    ifB.setIndex = '0; ifB.vecBase = 8'h40; ifB.aeoi = 1'b0; ifB.aeoiRotate = 1'b0;
    ifB.eoiSpecific = 1'b0; ifB.eoiRotate = 1'b0; ifB.eoiLevel = '0; ifB.priorityLevel = '0;

    #12;
    checkOutput("rst isr", ifA.isrValue, 8'h00);
    checkOutput("rst low", ifA.lowestPriority, 3'd7);
    checkOutput("rst highest", ifA.highestIndex, 3'd0);
    checkOutput("rst any", ifA.anyInService, 1'b0);
    checkOutput("rst vec", ifA.vectorOut, 8'h00);
    checkOutput("rst pulses", {ifA.setAck, ifA.vectorValid, ifA.eoiDone, ifA.protocolError,
                               ifA.spurious, ifA.clearedValid}, 6'b0);
    checkOutput("rst lowB", ifB.lowestPriority, 4'd15);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic set / vector / non-specific EOI
    setA(3'd3);
    checkOutput("set3 ack", ifA.setAck, 1'b1);
    checkOutput("set3 isr", ifA.isrValue, 8'h08);
    vecA();
    checkOutput("set3 ack drop", ifA.setAck, 1'b0);
    checkOutput("vec3 valid", ifA.vectorValid, 1'b1);
    checkOutput("vec3 out", ifA.vectorOut, 8'h43);
    checkOutput("vec3 spur", ifA.spurious, 1'b0);
    checkOutput("vec3 isr", ifA.isrValue, 8'h08);
    eoiA(1'b0, 1'b0, 3'd0);
    checkOutput("nseoi done", ifA.eoiDone, 1'b1);
    checkOutput("nseoi cv", ifA.clearedValid, 1'b1);
    checkOutput("nseoi ci", ifA.clearedIndex, 3'd3);
    checkOutput("nseoi isr", ifA.isrValue, 8'h00);

    // 16-line instance
    ifB.setValid = 1'b1; ifB.setIndex = 4'd13;
    applyStimulus();
    ifB.vectorReq = 1'b1;
    applyStimulus();
    checkOutput("B vec", ifB.vectorOut, 8'h4D);
    checkOutput("B isr", ifB.isrValue, 16'h2000);
    checkOutput("B highest", ifB.highestIndex, 4'd13);

    // AEOI with rotation
    ifA.aeoi = 1'b1; ifA.aeoiRotate = 1'b1;
    setA(3'd5);
    checkOutput("aeoi set isr", ifA.isrValue, 8'h20);
    vecA();
    checkOutput("aeoi vec", ifA.vectorOut, 8'h45);
    checkOutput("aeoi isr", ifA.isrValue, 8'h00);
    checkOutput("aeoi done", ifA.eoiDone, 1'b1);
    checkOutput("aeoi ci", ifA.clearedIndex, 3'd5);
    checkOutput("aeoi low", ifA.lowestPriority, 3'd5);
    ifA.aeoi = 1'b0; ifA.aeoiRotate = 1'b0;
    prioA(3'd7);
    checkOutput("prio7 low", ifA.lowestPriority, 3'd7);

    // Priority write, non-specific then specific rotating EOI
    setA(3'd2); vecA(); setA(3'd6); vecA();
    checkOutput("isr44", ifA.isrValue, 8'h44);
    checkOutput("isr44 highest", ifA.highestIndex, 3'd2);
    prioA(3'd3);
    checkOutput("prio3 highest", ifA.highestIndex, 3'd6);
    eoiA(1'b0, 1'b0, 3'd0);
    checkOutput("ns after prio isr", ifA.isrValue, 8'h04);
    checkOutput("ns after prio ci", ifA.clearedIndex, 3'd6);
    eoiA(1'b1, 1'b1, 3'd2);
    checkOutput("seoi isr", ifA.isrValue, 8'h00);
    checkOutput("seoi low", ifA.lowestPriority, 3'd2);
    checkOutput("empty highest", ifA.highestIndex, 3'd3);
    checkOutput("empty any", ifA.anyInService, 1'b0);
    eoiA(1'b0, 1'b1, 3'd0);
    checkOutput("empty eoi done", ifA.eoiDone, 1'b1);
    checkOutput("empty eoi cv", ifA.clearedValid, 1'b0);
    checkOutput("empty eoi low", ifA.lowestPriority, 3'd2);
    prioA(3'd7);

    // Spurious vector and protocol error
    vecA();
    checkOutput("spur vec", ifA.vectorOut, 8'h47);
    checkOutput("spur flag", ifA.spurious, 1'b1);
    checkOutput("spur valid", ifA.vectorValid, 1'b1);
    checkOutput("spur isr", ifA.isrValue, 8'h00);
    setA(3'd1);
    setA(3'd4);
    checkOutput("perr pulse", ifA.protocolError, 1'b1);
    checkOutput("perr isr", ifA.isrValue, 8'h02);
    vecA();
    checkOutput("perr drop", ifA.protocolError, 1'b0);
    checkOutput("perr vec", ifA.vectorOut, 8'h41);
    eoiA(1'b1, 1'b0, 3'd1);
    checkOutput("clr1 isr", ifA.isrValue, 8'h00);

    // Set and specific EOI on the same bit in one edge
    setA(3'd4); vecA();
    checkOutput("isr10", ifA.isrValue, 8'h10);
    ifA.setValid = 1'b1; ifA.setIndex = 3'd4;
    eoiA(1'b1, 1'b0, 3'd4);
    checkOutput("set+eoi isr", ifA.isrValue, 8'h10);
    vecA();
    eoiA(1'b1, 1'b0, 3'd4);
    checkOutput("clr4 isr", ifA.isrValue, 8'h00);

    // AEOI clear collides with an EOI command
    setA(3'd2); vecA();
    ifA.aeoi = 1'b1;
    setA(3'd0);
    ifA.vectorReq = 1'b1;
    eoiA(1'b0, 1'b0, 3'd0);
    checkOutput("coll perr", ifA.protocolError, 1'b1);
    checkOutput("coll done", ifA.eoiDone, 1'b1);
    checkOutput("coll ci", ifA.clearedIndex, 3'd0);
    checkOutput("coll isr", ifA.isrValue, 8'h04);
    checkOutput("coll low", ifA.lowestPriority, 3'd7);
    ifA.aeoi = 1'b0;
    eoiA(1'b1, 1'b0, 3'd2);
    checkOutput("coll clean", ifA.isrValue, 8'h00);

    // Asynchronous reset while ACKED
    setA(3'd3);
    prioA(3'd1);
    checkOutput("pre-rst isr", ifA.isrValue, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async isr", ifA.isrValue, 8'h00);
    checkOutput("async low", ifA.lowestPriority, 3'd7);
    #2 rst_n = 1'b1;
    vecA();
    checkOutput("post-rst vec", ifA.vectorOut, 8'h47);
    checkOutput("post-rst spur", ifA.spurious, 1'b1);
    checkOutput("post-rst isr", ifA.isrValue, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
